booth_div: RTL and testbench
============================

# booth_div

Sequential signed divider that inverts the Booth multiplier datapath. It accepts a 12-bit signed dividend (the full width of an 8-bit by 4-bit signed product) and an 8-bit signed divisor. It returns a truncated quotient and remainder after a fixed number of cycles. It sits beside the Booth multiplier in the arithmetic unit, shares its start/done style of control, and uses a radix-2 restoring algorithm on magnitudes followed by a sign fix-up.

## Interface
Parameters:
- DVD_W, 12: dividend and quotient width; signed two's complement.
- DVS_W, 8: divisor and remainder width; signed two's complement.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  DVD_W  signed dividend; captured on the accepting edge.
- divisor  in  DVS_W  signed divisor; captured on the accepting edge.
- busy  out  1  high from the accepting edge until done rises.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- quotient  out  DVD_W  signed quotient, truncated toward zero.
- remainder  out  DVS_W  signed remainder; its sign follows the dividend.
- dbz  out  1  divide-by-zero flag; valid with done.
- ovf  out  1  quotient-overflow flag; valid with done.

## Operation
- FSM states are IDLE, ITER and FIX.
- IDLE:
  - On start=1, capture |dividend| into the working register A and |divisor| into B.
  - Capture sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder R (DVS_W+1 bits) and the counter, then go to ITER.
- ITER (DVD_W cycles), one quotient bit per cycle:
  - Shift {R,A} left by 1.
  - Compute T = R - B, unsigned, DVS_W+1 bits.
  - If T >= 0, set R = T and A[0] = 1; otherwise set A[0] = 0.
  - The counter counts 0..DVD_W-1; after the last iteration, go to FIX.
- FIX, one cycle:
  - quotient = sign_q ? -A : A.
  - remainder = sign_r ? -R : R.
  - Compute the flags, pulse done, and return to IDLE.
- Divisor = 0:
  - The iteration runs unchanged.
  - FIX forces quotient to all ones, remainder to 0 and dbz to 1.
- Overflow:
  - Only dividend = -2048 with divisor = -1 overflows.
  - The quotient wraps to -2048 (0x800), remainder is 0 and ovf is 1.
- |dividend| of -2048 is 2048. A must be DVD_W+1 bits internally, or the -2048 case must be handled explicitly; either way the results above are required.
- start while busy is ignored; operands and state are unaffected.
- quotient, remainder, dbz and ovf hold their values until the next FIX.

## Timing
- Reset values: busy, done, quotient, remainder, dbz and ovf are all 0; the FSM is in IDLE. Reset takes effect immediately and asynchronously.
- Reset during ITER or FIX aborts the operation: no done pulse, and outputs return to their reset values.
- Latency: with start accepted at edge N, done is high in the cycle after edge N+DVD_W+1, which is N+13 by default. busy is high after edges N through N+DVD_W.
- Back-to-back operation: start may be high in the same cycle as done. It is accepted at the next edge because the FSM is already in IDLE, giving a throughput of one result every DVD_W+2 cycles.
- Arithmetic width: compare and subtract at DVS_W+1 bits, so |divisor| = 128 does not overflow.

## Configuration
- BOOTH_DIV_REM_EN defined: the remainder register and its negation are built, and remainder follows the rules above.
- BOOTH_DIV_REM_EN undefined:
  - The remainder port stays in the interface but is tied to 0.
  - R is still kept internally for the iteration, but no output register or negation is built.
  - quotient, the flags and latency are unchanged.

## Structure
- Package booth_pkg holds:
  - the DVD_W and DVS_W defaults and the counter width, $clog2(DVD_W);
  - the state enum {IDLE, ITER, FIX};
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_step: combinational shift, trial-subtract and select of {R,A} for a single iteration. It is instantiated once inside the FSM loop.

## Test plan
- dividend=100, divisor=7 -> quotient=14, remainder=2, dbz=0, ovf=0; done 13 cycles after accept.
- dividend=-100, divisor=7 -> quotient=-14, remainder=-2. dividend=100, divisor=-7 -> quotient=-14, remainder=2.
- dividend=-2048, divisor=-1 -> quotient=-2048 (0x800), remainder=0, ovf=1.
- divisor=0, dividend=55 -> quotient=0xFFF, remainder=0, dbz=1; same latency.
- start held through busy with changing operands -> only the first operands are used. Assert rst low at ITER cycle 5 -> no done pulse and all outputs 0. After reset, 63/-128 -> quotient=0, remainder=63.
- Back-to-back start on the done cycle -> the second result arrives 14 cycles after the first done. Also run a random sweep over all divisors and 1000 dividends against a truncating reference model, with and without BOOTH_DIV_REM_EN.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, state encoding and constants for booth_div
//
// Purpose: default operand widths, iteration counter width, divider FSM state
// encoding and the quotient returned on divide-by-zero.

package booth_pkg;

  localparam int DVD_W_DEF = 12;
  localparam int DVS_W_DEF = 8;
  localparam int CNT_W     = $clog2(DVD_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [DVD_W_DEF-1:0] DBZ_Q = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration on magnitudes
//
// Purpose: shift {R,A} left by one, trial-subtract B from the shifted R and
// select either the difference (quotient bit 1) or the shifted R (bit 0).
// Ports:
//   i_r  partial remainder, DVS_W+1 bits
//   i_a  working dividend / quotient bits, DVD_W bits
//   i_b  divisor magnitude, DVS_W bits
//   o_r  next partial remainder
//   o_a  next working register, new quotient bit in o_a[0]

module div_step #(
  parameter int DVD_W = 12,
  parameter int DVS_W = 8
) (
  input  logic [DVS_W:0]   i_r,
  input  logic [DVD_W-1:0] i_a,
  input  logic [DVS_W-1:0] i_b,
  output logic [DVS_W:0]   o_r,
  output logic [DVD_W-1:0] o_a
);

  logic [DVS_W:0] w_r_sh;
  logic [DVS_W:0] w_diff;
  logic           w_borrow;
  logic           w_ge;

  // The bit shifted out of i_r is kept as part of the compare: if it is set
  // the shifted value exceeds any DVS_W-bit divisor.
  assign w_r_sh             = {i_r[DVS_W-1:0], i_a[DVD_W-1]};
  assign {w_borrow, w_diff} = {1'b0, w_r_sh} - {2'b00, i_b};
  assign w_ge               = i_r[DVS_W] | ~w_borrow;

  assign o_r = w_ge ? w_diff : w_r_sh;
  assign o_a = {i_a[DVD_W-2:0], w_ge};

endmodule

// File: rtl/booth_div.sv
// rtl/booth_div.sv - sequential signed restoring divider with sign fix-up
//
// Purpose: divides a DVD_W-bit signed dividend by a DVS_W-bit signed divisor
// in DVD_W iterations on magnitudes, then applies signs in one FIX cycle.
// Build option: BOOTH_DIV_REM_EN builds the remainder output register; when
// undefined the remainder port is tied to zero.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request, sampled only in IDLE
//   dividend   signed dividend, captured on accept
//   divisor    signed divisor, captured on accept
//   busy       high from accept until done
//   done       one-cycle result pulse
//   quotient   signed quotient, truncated toward zero
//   remainder  signed remainder, sign follows dividend
//   dbz        divide-by-zero flag
//   ovf        quotient overflow flag (-2048 / -1 only)

module booth_div
  import booth_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_state_nxt;

  // A holds magnitudes as unsigned DVD_W bits: |-2048| = 0x800 still fits,
  // so the most negative dividend needs no extra width.
  logic [DVD_W-1:0] r_a;
  logic [DVS_W-1:0] r_b;
  logic [DVS_W:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;

  logic             r_done;
  logic             r_dbz;
  logic             r_ovf;
  logic [DVD_W-1:0] r_quot;

  logic [DVD_W-1:0] w_dvd_mag;
  logic [DVS_W-1:0] w_dvs_mag;
  logic [DVD_W-1:0] w_a_step;
  logic [DVS_W:0]   w_r_step;
  logic             w_accept;
  logic             w_last;
  logic             w_dbz;
  logic             w_ovf;
  logic [DVD_W-1:0] w_quot_fix;

  assign w_dvd_mag = dividend[DVD_W-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[DVS_W-1] ? -divisor : divisor;
  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_cnt == CNT_W'(DVD_W - 1));

  div_step #(
    .DVD_W (DVD_W),
    .DVS_W (DVS_W)
  ) u_step (
    .i_r (r_r),
    .i_a (r_a),
    .i_b (r_b),
    .o_r (w_r_step),
    .o_a (w_a_step)
  );

  // A quotient magnitude with its top bit set is 2048; with a positive sign
  // that value is not representable, which only -2048 / -1 produces.
  assign w_dbz      = (r_b == '0);
  assign w_ovf      = ~w_dbz & ~r_sign_q & r_a[DVD_W-1];
  assign w_quot_fix = w_dbz ? DVD_W'(DBZ_Q) : (r_sign_q ? -r_a : r_a);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ITER;
      ITER:    if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_quot   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= w_dvd_mag;
            r_b      <= w_dvs_mag;
            r_r      <= '0;
            r_cnt    <= '0;
            r_sign_q <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
          end
        end
        ITER: begin
          r_a   <= w_a_step;
          r_r   <= w_r_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_quot <= w_quot_fix;
          r_dbz  <= w_dbz;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOOTH_DIV_REM_EN
  logic             r_sign_r;
  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] w_rem_mag;
  logic [DVS_W-1:0] w_rem_fix;

  // The final R is below |divisor| <= 2^(DVS_W-1), so its top bit is zero.
  assign w_rem_mag = r_r[DVS_W-1:0];
  assign w_rem_fix = w_dbz ? '0 : (r_sign_r ? -w_rem_mag : w_rem_mag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign_r <= 1'b0;
      r_rem    <= '0;
    end else begin
      if (w_accept) r_sign_r <= dividend[DVD_W-1];
      if (r_state == FIX) r_rem <= w_rem_fix;
    end
  end

  assign remainder = r_rem;
`else
  assign remainder = '0;
`endif

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign quotient = r_quot;
  assign dbz      = r_dbz;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_booth_div.sv
// tb/tb_booth_div.sv - directed self-checking bench for booth_div

module tb_booth_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;
  logic        ovf;

  int n_pass  = 0;
  int n_total = 0;

`ifdef BOOTH_DIV_REM_EN
  localparam logic [7:0] REM_MASK = 8'hFF;
`else
  localparam logic [7:0] REM_MASK = 8'h00;
`endif

  always #5 clk = ~clk;

  booth_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  // Drives one operation and collects results; lat counts rising edges from
  // the accepting edge to the edge after which done is seen (-1 on timeout).
  task automatic run_op(input logic [11:0] a, input logic [7:0] b,
                        output logic [11:0] q, output logic [7:0] r,
                        output logic dz, output logic ov,
                        output int lat, output logic bsy);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    bsy   = busy;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) lat = -1;
    q  = quotient;
    r  = remainder;
    dz = dbz;
    ov = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #3 rst = 1'b0;
    #1;
    n_total++;
    if ({busy, done, quotient, remainder, dbz, ovf} !== 24'h0)
      $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               busy, done, quotient, remainder, dbz, ovf);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] a_v [4] = '{12'd100, -12'sd100, 12'd100, 12'd2047};
    logic [7:0]  b_v [4] = '{8'd7, 8'd7, -8'sd7, -8'sd128};
    logic [11:0] q_v [4] = '{12'h00E, 12'hFF2, 12'hFF2, 12'hFF1};
    logic [7:0]  r_v [4] = '{8'h02, 8'hFE, 8'h02, 8'h7F};
    logic [11:0] q; logic [7:0] r; logic dz, ov, bsy; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(a_v[i], b_v[i], q, r, dz, ov, lat, bsy);
      n_total++;
      if (q !== q_v[i]) $display("FAIL basic_q[%0d] got %h want %h", i, q, q_v[i]);
      else n_pass++;
      n_total++;
      if (r !== (r_v[i] & REM_MASK))
        $display("FAIL basic_r[%0d] got %h want %h", i, r, r_v[i] & REM_MASK);
      else n_pass++;
      n_total++;
      if ({dz, ov, bsy} !== 3'b001 || lat != 13)
        $display("FAIL basic_ctl[%0d] got dbz=%b ovf=%b busy=%b lat=%0d want 0 0 1 13",
                 i, dz, ov, bsy, lat);
      else n_pass++;
    end
  endtask

  task automatic test_boundary();
    logic [11:0] a_v [5] = '{12'h800, 12'h800, 12'd55, 12'h800, 12'h800};
    logic [7:0]  b_v [5] = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h80};
    logic [11:0] q_v [5] = '{12'h800, 12'h800, 12'hFFF, 12'hFFF, 12'h010};
    logic [1:0]  f_v [5] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [11:0] q; logic [7:0] r; logic dz, ov, bsy; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(a_v[i], b_v[i], q, r, dz, ov, lat, bsy);
      n_total++;
      if (q !== q_v[i] || r !== 8'h00 || {dz, ov} !== f_v[i] || lat != 13)
        $display("FAIL boundary[%0d] got q=%h r=%h dbz=%b ovf=%b lat=%0d want q=%h r=00 flags=%b lat=13",
                 i, q, r, dz, ov, lat, q_v[i], f_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    int  lat = 0;
    logic all_busy = 1'b1;
    @(negedge clk);
    dividend = 12'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    while (!done && lat < 40) begin
      all_busy &= busy;
      dividend = 12'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    n_total++;
    if (quotient !== 12'h00E || remainder !== (8'h02 & REM_MASK) || !all_busy || lat != 13)
      $display("FAIL start_held got q=%h r=%h busy_held=%b lat=%0d want q=00e r=%h 1 13",
               quotient, remainder, all_busy, lat, 8'h02 & REM_MASK);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic saw_done = 1'b0;
    logic [11:0] q; logic [7:0] r; logic dz, ov, bsy; int lat;
    @(negedge clk);
    dividend = 12'd300; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++;
    if ({busy, done, quotient, remainder, dbz, ovf} !== 24'h0)
      $display("FAIL abort_outputs got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               busy, done, quotient, remainder, dbz, ovf);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    n_total++;
    if (saw_done) $display("FAIL abort_no_done got done/busy activity want none");
    else n_pass++;
    run_op(12'd63, 8'h80, q, r, dz, ov, lat, bsy);
    n_total++;
    if (q !== 12'h000 || r !== (8'h3F & REM_MASK) || {dz, ov} !== 2'b00 || lat != 13)
      $display("FAIL after_reset got q=%h r=%h dbz=%b ovf=%b lat=%0d want q=000 r=%h 0 0 13",
               q, r, dz, ov, lat, 8'h3F & REM_MASK);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] q; logic [7:0] r; logic dz, ov, bsy; int lat;
    run_op(12'd100, 8'd7, q, r, dz, ov, lat, bsy);
    dividend = -12'sd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    bsy   = busy;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_total++;
    if (quotient !== 12'hFF2 || remainder !== (8'hFE & REM_MASK) || !bsy || lat != 14)
      $display("FAIL back_to_back got q=%h r=%h busy=%b gap=%0d want q=ff2 r=%h 1 14",
               quotient, remainder, bsy, lat, 8'hFE & REM_MASK);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [11:0] q, a, qe; logic [7:0] r, b, re; logic dz, ov, bsy, dze, ove; int lat, ia, ib;
    for (int i = 0; i < 60; i++) begin
      a = 12'($urandom);
      b = (i % 10 == 3) ? 8'h00 : 8'($urandom);
      ia = $signed(a);
      ib = $signed(b);
      if (ib == 0) begin
        qe = 12'hFFF; re = 8'h00; dze = 1'b1; ove = 1'b0;
      end else begin
        qe = 12'(ia / ib); re = 8'(ia % ib); dze = 1'b0;
        ove = (ia == -2048 && ib == -1);
      end
      run_op(a, b, q, r, dz, ov, lat, bsy);
      n_total++;
      if (q !== qe || r !== (re & REM_MASK) || dz !== dze || ov !== ove || lat != 13)
        $display("FAIL sweep %0d/%0d got q=%h r=%h dbz=%b ovf=%b lat=%0d want q=%h r=%h dbz=%b ovf=%b",
                 ia, ib, q, r, dz, ov, lat, qe, re & REM_MASK, dze, ove);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_start_held();
    test_abort();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
